// File: rtl/spi_pkg.sv
// Shared types and helpers for the full-duplex SPI slave.
// The sample-edge polarity follows from the CPOL/CPHA pair.
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } spi_slv_state_t;

  // Modes 0 and 3 sample on the rising sclk edge; modes 1 and 2 sample on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input.
// Produces registered one-clk rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // The extra register stage on the pulses gives SYNC_STAGES+1 clk of latency from a pin edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_fd.sv
// Full-duplex SPI slave that oversamples sclk/ss_n/mosi in the clk domain.
// It supports back-to-back words per frame and flags completion, underrun and abort.
module spi_slave_fd
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int               CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam logic             SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ss_level, ss_fall, ss_rise_unused;
  logic sample_edge, shift_edge, mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .din(ss_n),
    .level(ss_level), .rise(ss_rise_unused), .fall(ss_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  spi_slv_state_t state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, hold_q, hold_d;
  logic [DATA_W-1:0] rx_next, tx_next;
  logic hold_full_q, hold_full_d, skip_q, skip_d, miso_oe_q, miso_oe_d;
  logic rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
  logic frame_abort_q, frame_abort_d, word_done;

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    if (MSB_FIRST) begin
      rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};
      tx_next = {tx_shift_q[DATA_W-2:0], 1'b0};
    end else begin
      rx_next = {mosi_s, rx_shift_q[DATA_W-1:1]};
      tx_next = {1'b0, tx_shift_q[DATA_W-1:1]};
    end
  end

  // skip_q suppresses the one shift edge that must not advance miso after a (re)load.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    skip_d        = skip_q;
    miso_oe_d     = miso_oe_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    word_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        miso_oe_d = 1'b0;
        bit_cnt_d = '0;
        skip_d    = 1'b0;
        if (ss_fall && !ss_level) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hold_full_q) begin
          tx_shift_d = hold_q;
        end else begin
          tx_shift_d    = '0;
          tx_underrun_d = 1'b1;
        end
        hold_full_d = 1'b0;
        miso_oe_d   = 1'b1;
        if (CPHA) skip_d = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (sample_edge) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            word_done  = 1'b1;
            state_d    = S_LOAD;
            if (!CPHA) skip_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          if (skip_q) skip_d = 1'b0;
          else        tx_shift_d = tx_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A word completing in the same clk as ss_n rising still counts; only a partial word aborts.
    if (state_q != S_IDLE && ss_level) begin
      state_d   = S_IDLE;
      miso_oe_d = 1'b0;
      bit_cnt_d = '0;
      skip_d    = 1'b0;
      if (bit_cnt_q != '0 && !word_done) frame_abort_d = 1'b1;
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_sync_q   <= '0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      skip_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      skip_q        <= skip_d;
      miso_oe_q     <= miso_oe_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = miso_oe_q & (MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_fd.sv
// Directed bench for spi_slave_fd: three instances (mode 0 / 8 bit, mode 3 / 8 bit,
// mode 0 / 16 bit LSB first) share one bit-banged SPI master selected by sel.
module tb_spi_slave_fd;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int sel;
  logic busSclk, busSs, busMosi, busMiso;
  logic [15:0] txData;
  logic txValid0, txValid3, txValid16;

  logic sclk0, sclk3, sclk16, ss0, ss3, ss16;
  logic miso0, miso3, miso16, oe0, oe3, oe16;
  logic ready0, ready3, ready16, rxValid0, rxValid3, rxValid16;
  logic urun0, urun3, urun16, abort0, abort3, abort16;
  logic [7:0] rxData0, rxData3;
  logic [15:0] rxData16;

  int assertCount = 0;
  int failCount = 0;
  int rxvCnt[3];
  int abortCnt[3];
  int urunCnt[3];

  assign sclk0  = (sel == 0) ? busSclk : 1'b0;
  assign sclk3  = (sel == 1) ? busSclk : 1'b1;
  assign sclk16 = (sel == 2) ? busSclk : 1'b0;
  assign ss0    = (sel == 0) ? busSs : 1'b1;
  assign ss3    = (sel == 1) ? busSs : 1'b1;
  assign ss16   = (sel == 2) ? busSs : 1'b1;
  assign busMiso = (sel == 0) ? miso0 : (sel == 1) ? miso3 : miso16;

  spi_slave_fd #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclk0), .ss_n(ss0), .mosi(busMosi), .miso(miso0),
    .miso_oe(oe0), .tx_data(txData[7:0]), .tx_valid(txValid0), .tx_ready(ready0),
    .rx_data(rxData0), .rx_valid(rxValid0), .tx_underrun(urun0), .frame_abort(abort0));

  spi_slave_fd #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .sclk(sclk3), .ss_n(ss3), .mosi(busMosi), .miso(miso3),
    .miso_oe(oe3), .tx_data(txData[7:0]), .tx_valid(txValid3), .tx_ready(ready3),
    .rx_data(rxData3), .rx_valid(rxValid3), .tx_underrun(urun3), .frame_abort(abort3));

  spi_slave_fd #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .sclk(sclk16), .ss_n(ss16), .mosi(busMosi), .miso(miso16),
    .miso_oe(oe16), .tx_data(txData), .tx_valid(txValid16), .tx_ready(ready16),
    .rx_data(rxData16), .rx_valid(rxValid16), .tx_underrun(urun16), .frame_abort(abort16));

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rxValid0)  rxvCnt[0]++;
    if (rxValid3)  rxvCnt[1]++;
    if (rxValid16) rxvCnt[2]++;
    if (abort0)    abortCnt[0]++;
    if (abort3)    abortCnt[1]++;
    if (abort16)   abortCnt[2]++;
    if (urun0)     urunCnt[0]++;
    if (urun3)     urunCnt[1]++;
    if (urun16)    urunCnt[2]++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushTx(input int which, input logic [15:0] d);
    @(negedge clk);
    txData = d;
    case (which)
      0: txValid0 = 1'b1;
      1: txValid3 = 1'b1;
      default: txValid16 = 1'b1;
    endcase
    @(negedge clk);
    txValid0 = 1'b0;
    txValid3 = 1'b0;
    txValid16 = 1'b0;
  endtask

  task automatic selectDut(input int k);
    busSs = 1'b1;
    sel = k;
    busSclk = (k == 1);
    waitClk(8);
  endtask

  task automatic startFrame();
    busSs = 1'b0;
    waitClk(8);
  endtask

  task automatic endFrame();
    waitClk(4);
    busSs = 1'b1;
    waitClk(8);
  endtask

  // Bit-banged master: half period of 8 clk, mode and order taken from the selected slave.
  task automatic applyStimulus(input logic [15:0] mo, input int nbits, output logic [15:0] mi);
    int w, b;
    logic cpol, cpha, lsb;
    w = (sel == 2) ? 16 : 8;
    cpol = (sel == 1);
    cpha = (sel == 1);
    lsb = (sel == 2);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : w - 1 - i;
      if (!cpha) begin
        busMosi = mo[b];
        waitClk(8);
        busSclk = ~cpol;
        mi[b] = busMiso;
        waitClk(8);
        busSclk = cpol;
      end else begin
        busSclk = ~cpol;
        busMosi = mo[b];
        waitClk(8);
        busSclk = cpol;
        mi[b] = busMiso;
        waitClk(8);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] got;
    int rxBase, abBase, urBase;
    reset = 1'b1;
    busSclk = 1'b0; busSs = 1'b1; busMosi = 1'b0; sel = 0;
    txData = '0; txValid0 = 1'b0; txValid3 = 1'b0; txValid16 = 1'b0;
    waitClk(3);
    reset = 1'b0;
    waitClk(2);

    $display("[TB] reset state");
    checkOutput("rst tx_ready", ready0, 1);
    checkOutput("rst miso_oe", oe0, 0);
    checkOutput("rst miso", miso0, 0);
    checkOutput("rst rx_valid", rxValid0, 0);
    checkOutput("rst rx_data", rxData0, 0);
    checkOutput("rst underrun", urun0, 0);
    checkOutput("rst abort", abort0, 0);
    checkOutput("rst tx_ready m3", ready3, 1);

    $display("[TB] test 1: mode 0");
    pushTx(0, 16'h003C);
    checkOutput("t1 tx_ready busy", ready0, 0);
    rxBase = rxvCnt[0]; urBase = urunCnt[0];
    startFrame();
    checkOutput("t1 tx_ready after load", ready0, 1);
    checkOutput("t1 miso_oe active", oe0, 1);
    applyStimulus(16'h00A5, 8, got);
    endFrame();
    checkOutput("t1 rx_data", rxData0, 8'hA5);
    checkOutput("t1 rx_valid count", rxvCnt[0] - rxBase, 1);
    checkOutput("t1 master read", got, 16'h003C);
    checkOutput("t1 underrun on reload", urunCnt[0] - urBase, 1);
    checkOutput("t1 miso_oe after", oe0, 0);

    $display("[TB] test 2: mode 3");
    selectDut(1);
    checkOutput("t2 miso_oe before", oe3, 0);
    pushTx(1, 16'h003C);
    rxBase = rxvCnt[1];
    startFrame();
    checkOutput("t2 miso_oe active", oe3, 1);
    applyStimulus(16'h00A5, 8, got);
    endFrame();
    checkOutput("t2 rx_data", rxData3, 8'hA5);
    checkOutput("t2 rx_valid count", rxvCnt[1] - rxBase, 1);
    checkOutput("t2 master read", got, 16'h003C);
    checkOutput("t2 miso_oe after", oe3, 0);
    checkOutput("t2 no abort", abortCnt[1], 0);

    $display("[TB] test 3: 16 bit LSB first, back-to-back");
    selectDut(2);
    pushTx(2, 16'h1234);
    rxBase = rxvCnt[2];
    startFrame();
    checkOutput("t3 tx_ready after load", ready16, 1);
    pushTx(2, 16'hBEEF);
    applyStimulus(16'h00FF, 16, got);
    checkOutput("t3 word1 read", got, 16'h1234);
    checkOutput("t3 word1 rx", rxData16, 16'h00FF);
    applyStimulus(16'hF00D, 16, got);
    checkOutput("t3 word2 read", got, 16'hBEEF);
    checkOutput("t3 word2 rx", rxData16, 16'hF00D);
    endFrame();
    checkOutput("t3 rx_valid count", rxvCnt[2] - rxBase, 2);

    $display("[TB] test 4: abort after 5 bits");
    selectDut(0);
    pushTx(0, 16'h0081);
    rxBase = rxvCnt[0]; abBase = abortCnt[0];
    startFrame();
    applyStimulus(16'h00FF, 5, got);
    endFrame();
    checkOutput("t4 partial read", got, 16'h0080);
    checkOutput("t4 abort count", abortCnt[0] - abBase, 1);
    checkOutput("t4 no rx_valid", rxvCnt[0] - rxBase, 0);
    checkOutput("t4 rx_data kept", rxData0, 8'hA5);
    pushTx(0, 16'h0096);
    startFrame();
    applyStimulus(16'h005A, 8, got);
    endFrame();
    checkOutput("t4 next rx", rxData0, 8'h5A);
    checkOutput("t4 next read", got, 16'h0096);
    checkOutput("t4 single abort", abortCnt[0] - abBase, 1);

    $display("[TB] test 5: underrun");
    urBase = urunCnt[0];
    startFrame();
    applyStimulus(16'h00C3, 8, got);
    endFrame();
    checkOutput("t5 underrun count", urunCnt[0] - urBase, 2);
    checkOutput("t5 master read", got, 16'h0000);
    checkOutput("t5 rx_data", rxData0, 8'hC3);

    $display("[TB] test 6: reset mid-word");
    pushTx(0, 16'h0077);
    rxBase = rxvCnt[0]; abBase = abortCnt[0];
    startFrame();
    applyStimulus(16'h00FF, 3, got);
    pushTx(0, 16'h0011);
    checkOutput("t6 holding full", ready0, 0);
    @(negedge clk);
    reset = 1'b1;
    busSs = 1'b1;
    waitClk(2);
    checkOutput("t6 rst tx_ready", ready0, 1);
    checkOutput("t6 rst rx_data", rxData0, 0);
    checkOutput("t6 rst miso_oe", oe0, 0);
    checkOutput("t6 rst miso", miso0, 0);
    checkOutput("t6 rst rx_valid", rxValid0, 0);
    reset = 1'b0;
    waitClk(8);
    checkOutput("t6 no abort", abortCnt[0] - abBase, 0);
    checkOutput("t6 no rx_valid", rxvCnt[0] - rxBase, 0);
    pushTx(0, 16'h003C);
    startFrame();
    applyStimulus(16'h00A5, 8, got);
    endFrame();
    checkOutput("t6 recover rx", rxData0, 8'hA5);
    checkOutput("t6 recover read", got, 16'h003C);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
